// File: rtl/refresh_pkg.sv
// Shared types and constants for the DRAM refresh scheduler.
// No logic of its own; pure declarations.
// No flow control; consumed by refi_timer and refresh_scheduler.
package refresh_pkg;

   // Refresh operation sequence for one rank.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_DECIDE = 3'd2,
      ST_REQ    = 3'd3,
      ST_RFC    = 3'd4
   } refresh_state_t;

   localparam int STATE_W      = 3;
   localparam int SKIP_W       = 16;
   localparam int ROW_W_DEF    = 16;
   localparam int POSTPONE_DEF = 8;

   localparam int REFI_DEFAULT = 3120;
   localparam int RFC_DEFAULT  = 280;

   // Counter width able to hold 0..n-1 (never less than one bit).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/refi_timer.sv
// tREFI interval timer and postponed-refresh credit bank with overflow flag.
// Tick is combinational on the last count; credit/urgent/overflow update on that edge.
// No backpressure: ticks at the credit ceiling are dropped and flagged sticky.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   ref_en       timer advances only while high
//   consume      one credit retired this cycle (dummy decision or grant)
//   tick         one-cycle strobe at the terminal count
//   credit       pending refresh count, saturates at MAX_POSTPONE
//   urgent       registered credit == MAX_POSTPONE
//   overflow     sticky; a tick was lost at the ceiling
module refi_timer
   import refresh_pkg::*;
#(
   parameter int T_REFI       = REFI_DEFAULT,
   parameter int MAX_POSTPONE = POSTPONE_DEF
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  ref_en,
   input  logic                                  consume,
   output logic                                  tick,
   output logic [$clog2(MAX_POSTPONE+1)-1:0]     credit,
   output logic                                  urgent,
   output logic                                  overflow
);

   localparam int CNT_W  = cnt_w(T_REFI);
   localparam int CRED_W = $clog2(MAX_POSTPONE+1);

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(T_REFI - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_POSTPONE);
   localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

   logic [CNT_W-1:0]  r_cnt;
   logic [CRED_W-1:0] r_credit;
   logic              r_urgent;
   logic              r_overflow;

   logic              w_tick;
   logic [CRED_W-1:0] w_credit_nxt;
   logic              w_ovf_set;

   assign w_tick = ref_en && (r_cnt == CNT_LAST);

   // Tick and consume together cancel; a lone tick at the ceiling is lost.
   always_comb begin
      w_credit_nxt = r_credit;
      w_ovf_set    = 1'b0;
      if (w_tick && !consume) begin
         if (r_credit == CRED_MAX) begin
            w_ovf_set = 1'b1;
         end else begin
            w_credit_nxt = r_credit + CRED_ONE;
         end
      end else if (!w_tick && consume && (r_credit != '0)) begin
         w_credit_nxt = r_credit - CRED_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_credit   <= '0;
         r_urgent   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (ref_en) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
         end
         r_credit   <= w_credit_nxt;
         r_urgent   <= (w_credit_nxt == CRED_MAX);
         r_overflow <= r_overflow | w_ovf_set;
      end
   end

   assign tick     = w_tick;
   assign credit   = r_credit;
   assign urgent   = r_urgent;
   assign overflow = r_overflow;

endmodule

// File: rtl/refresh_scheduler.sv
// Per-row refresh sequencer: tracker lookup, dummy retire or arbiter request, tRFC hold-off.
// lk_req one cycle after credit seen in IDLE, ref_req two cycles later; dummies take 3 cycles.
// ref_req held with a stable row until ref_gnt; credits bank while the arbiter stalls.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   ref_en                  enables timer and new operations
//   lk_req/lk_row/lk_dummy  peak-tracker lookup strobe, row, answer (next cycle)
//   ref_req/ref_gnt         command-arbiter handshake; ref_row is the row pointer
//   ref_urgent              credit at ceiling, arbiter must block normal traffic
//   ref_busy                rank busy during tRFC
//   credit, skip_cnt        pending refreshes, saturating dummy count
//   ref_overflow            sticky lost-tick flag
module refresh_scheduler
   import refresh_pkg::*;
#(
   parameter int ROW_WIDTH    = ROW_W_DEF,
   parameter int T_REFI       = REFI_DEFAULT,
   parameter int T_RFC        = RFC_DEFAULT,
   parameter int MAX_POSTPONE = POSTPONE_DEF
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               ref_en,
   output logic                               lk_req,
   output logic [ROW_WIDTH-1:0]               lk_row,
   input  logic                               lk_dummy,
   output logic                               ref_req,
   output logic                               ref_urgent,
   input  logic                               ref_gnt,
   output logic [ROW_WIDTH-1:0]               ref_row,
   output logic                               ref_busy,
   output logic [$clog2(MAX_POSTPONE+1)-1:0]  credit,
   output logic [SKIP_W-1:0]                  skip_cnt,
   output logic                               ref_overflow
);

   localparam int RFC_W = cnt_w(T_RFC);

   localparam logic [RFC_W-1:0]     RFC_LAST = RFC_W'(T_RFC - 1);
   localparam logic [RFC_W-1:0]     RFC_ONE  = RFC_W'(1);
   localparam logic [ROW_WIDTH-1:0] ROW_ONE  = ROW_WIDTH'(1);
   localparam logic [SKIP_W-1:0]    SKIP_ONE = SKIP_W'(1);

   refresh_state_t                      r_state;
   refresh_state_t                      w_state_nxt;
   logic [ROW_WIDTH-1:0]                r_row;
   logic [RFC_W-1:0]                    r_rfc_cnt;
   logic [SKIP_W-1:0]                   r_skip;
   logic                                r_busy;

   logic                                w_consume;
   logic                                w_row_inc;
   logic                                w_skip_inc;
   logic                                w_tick;
   logic [$clog2(MAX_POSTPONE+1)-1:0]   w_credit;
   logic                                w_urgent;
   logic                                w_overflow;

   refi_timer #(
      .T_REFI       (T_REFI),
      .MAX_POSTPONE (MAX_POSTPONE)
   ) u_refi_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .ref_en   (ref_en),
      .consume  (w_consume),
      .tick     (w_tick),
      .credit   (w_credit),
      .urgent   (w_urgent),
      .overflow (w_overflow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ref_en only gates leaving IDLE; anything already started runs to completion.
   always_comb begin
      w_state_nxt = r_state;
      w_consume   = 1'b0;
      w_row_inc   = 1'b0;
      w_skip_inc  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if ((w_credit != '0) && ref_en) w_state_nxt = ST_LOOKUP;
         end
         ST_LOOKUP: w_state_nxt = ST_DECIDE;
         ST_DECIDE: begin
            if (lk_dummy) begin
               w_consume   = 1'b1;
               w_row_inc   = 1'b1;
               w_skip_inc  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ref_gnt) begin
               w_consume   = 1'b1;
               w_row_inc   = 1'b1;
               w_state_nxt = ST_RFC;
            end
         end
         ST_RFC: begin
            if (r_rfc_cnt == RFC_LAST) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row     <= '0;
         r_rfc_cnt <= '0;
         r_skip    <= '0;
         r_busy    <= 1'b0;
      end else begin
         if (w_row_inc) r_row <= r_row + ROW_ONE;
         if (w_skip_inc && (r_skip != '1)) r_skip <= r_skip + SKIP_ONE;
         // Counts cycles spent in RFC; zero on entry.
         r_rfc_cnt <= (r_state == ST_RFC) ? r_rfc_cnt + RFC_ONE : '0;
         r_busy    <= (w_state_nxt == ST_RFC);
      end
   end

   assign lk_req       = (r_state == ST_LOOKUP);
   assign ref_req      = (r_state == ST_REQ);
   assign lk_row       = r_row;
   assign ref_row      = r_row;
   assign ref_busy     = r_busy;
   assign skip_cnt     = r_skip;
   assign credit       = w_credit;
   assign ref_urgent   = w_urgent;
   assign ref_overflow = w_overflow;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Scoreboard bench for refresh_scheduler with a cycle-level reference of the refresh rules.
// Expected lookups/requests are queued by the model and popped by an output monitor.
// Randomized ref_en / lk_dummy / ref_gnt plus directed postponement and reset-in-request.
module tb_refresh_scheduler;

   localparam int RW   = 4;
   localparam int TREFI = 10;
   localparam int TRFC = 4;
   localparam int MAXP = 4;
   localparam int CW   = $clog2(MAXP+1);

   localparam int PH_IDLE   = 0;
   localparam int PH_LOOKUP = 1;
   localparam int PH_DECIDE = 2;
   localparam int PH_REQ    = 3;
   localparam int PH_BUSY   = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ref_en = 1'b0;
   logic          lk_dummy = 1'b0;
   logic          ref_gnt = 1'b0;
   logic          lk_req;
   logic [RW-1:0] lk_row;
   logic          ref_req;
   logic          ref_urgent;
   logic [RW-1:0] ref_row;
   logic          ref_busy;
   logic [CW-1:0] credit;
   logic [15:0]   skip_cnt;
   logic          ref_overflow;

   refresh_scheduler #(
      .ROW_WIDTH    (RW),
      .T_REFI       (TREFI),
      .T_RFC        (TRFC),
      .MAX_POSTPONE (MAXP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ref_en       (ref_en),
      .lk_req       (lk_req),
      .lk_row       (lk_row),
      .lk_dummy     (lk_dummy),
      .ref_req      (ref_req),
      .ref_urgent   (ref_urgent),
      .ref_gnt      (ref_gnt),
      .ref_row      (ref_row),
      .ref_busy     (ref_busy),
      .credit       (credit),
      .skip_cnt     (skip_cnt),
      .ref_overflow (ref_overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state
   int cyc = 0;
   int m_cnt = 0;
   int m_credit = 0;
   int m_old_credit = 0;
   int m_row = 0;
   int m_skip = 0;
   int m_ph = PH_IDLE;
   int m_busy_left = 0;
   bit m_ovf = 1'b0;
   bit m_tick = 1'b0;
   bit m_cons = 1'b0;

   int q_lk_cyc[$];
   int q_lk_row[$];
   int q_req_cyc[$];
   int q_req_row[$];

   int first_lk_cyc = -1;
   int first_req_cyc = -1;
   int n_req_rise = 0;
   bit prev_req = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   // Reference model: applies the refresh rules to the bench's own inputs at each edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; m_cnt = 0; m_credit = 0; m_ovf = 1'b0;
         m_row = 0; m_skip = 0; m_ph = PH_IDLE; m_busy_left = 0;
         q_lk_cyc.delete(); q_lk_row.delete();
         q_req_cyc.delete(); q_req_row.delete();
         first_lk_cyc = -1; first_req_cyc = -1; prev_req = 1'b0;
      end else begin
         cyc = cyc + 1;
         m_tick = ref_en && (m_cnt == TREFI-1);
         if (ref_en) m_cnt = (m_cnt + 1) % TREFI;
         m_cons = (m_ph == PH_DECIDE && lk_dummy) || (m_ph == PH_REQ && ref_gnt);
         m_old_credit = m_credit;
         m_credit = m_credit + int'(m_tick) - int'(m_cons);
         if (m_credit > MAXP) begin
            m_credit = MAXP;
            m_ovf = 1'b1;
         end
         case (m_ph)
            PH_IDLE: if (m_old_credit > 0 && ref_en) begin
               m_ph = PH_LOOKUP;
               q_lk_cyc.push_back(cyc);
               q_lk_row.push_back(m_row);
            end
            PH_LOOKUP: m_ph = PH_DECIDE;
            PH_DECIDE: if (lk_dummy) begin
               m_row = (m_row + 1) % (1 << RW);
               if (m_skip < 65535) m_skip = m_skip + 1;
               m_ph = PH_IDLE;
            end else begin
               m_ph = PH_REQ;
               q_req_cyc.push_back(cyc);
               q_req_row.push_back(m_row);
            end
            PH_REQ: if (ref_gnt) begin
               m_row = (m_row + 1) % (1 << RW);
               m_busy_left = TRFC;
               m_ph = PH_BUSY;
            end
            default: begin
               m_busy_left = m_busy_left - 1;
               if (m_busy_left == 0) m_ph = PH_IDLE;
            end
         endcase
      end
   end

   // Monitor: registered outputs every cycle, handshake strobes against the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("credit", int'(credit), m_credit);
         chk("ref_urgent", int'(ref_urgent), int'(m_credit == MAXP));
         chk("ref_overflow", int'(ref_overflow), int'(m_ovf));
         chk("ref_busy", int'(ref_busy), int'(m_ph == PH_BUSY));
         chk("ref_row", int'(ref_row), m_row);
         chk("skip_cnt", int'(skip_cnt), m_skip);

         while (q_lk_cyc.size() > 0 && q_lk_cyc[0] < cyc) begin
            chk("lk_req_missing", 0, 1);
            void'(q_lk_cyc.pop_front());
            void'(q_lk_row.pop_front());
         end
         if (lk_req) begin
            if (first_lk_cyc < 0) first_lk_cyc = cyc;
            if (q_lk_cyc.size() == 0) chk("lk_req_unexpected", 1, 0);
            else begin
               chk("lk_req_cycle", cyc, q_lk_cyc.pop_front());
               chk("lk_row", int'(lk_row), q_lk_row.pop_front());
            end
         end

         while (q_req_cyc.size() > 0 && q_req_cyc[0] < cyc) begin
            chk("ref_req_missing", 0, 1);
            void'(q_req_cyc.pop_front());
            void'(q_req_row.pop_front());
         end
         if (ref_req && !prev_req) begin
            n_req_rise++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            if (q_req_cyc.size() == 0) chk("ref_req_unexpected", 1, 0);
            else begin
               chk("ref_req_cycle", cyc, q_req_cyc.pop_front());
               chk("ref_req_row", int'(ref_row), q_req_row.pop_front());
            end
         end
         prev_req = ref_req;
      end
   end

   task automatic run_cycles(input int n, input int en_mode, input int dum_mode, input int gnt_mode);
      // modes: 0 = drive 0, 1 = drive 1, 2 = random, 3 (gnt only) = follow ref_req
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ref_en   = (en_mode == 2) ? ($urandom_range(0, 9) != 0) : (en_mode == 1);
         lk_dummy = (dum_mode == 2) ? $urandom_range(0, 1) : (dum_mode == 1);
         case (gnt_mode)
            2:       ref_gnt = $urandom_range(0, 1);
            3:       ref_gnt = ref_req;
            default: ref_gnt = (gnt_mode == 1);
         endcase
      end
   endtask

   initial begin
      int base;
      int waited;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ref_en = 1'b1;

      // Auto refresh, long enough for the row pointer to wrap.
      run_cycles(220, 1, 0, 3);
      chk("first_lk_cycle", first_lk_cyc, 11);
      chk("first_req_cycle", first_req_cyc, 13);

      // All rows dummy: no requests after settling.
      run_cycles(15, 1, 1, 1);
      base = n_req_rise;
      run_cycles(60, 1, 1, 2);
      chk("dummy_no_request", n_req_rise - base, 0);

      // Postponement: arbiter stalls until credit saturates and a tick is lost.
      run_cycles(65, 1, 0, 0);
      chk("postpone_credit", int'(credit), MAXP);
      chk("postpone_urgent", int'(ref_urgent), 1);
      chk("postpone_overflow", int'(ref_overflow), 1);

      // Drain, then fully random traffic.
      run_cycles(80, 1, 0, 2);
      run_cycles(500, 2, 2, 2);

      // Reset while a request is outstanding.
      ref_en = 1'b1; lk_dummy = 1'b0; ref_gnt = 1'b0;
      waited = 0;
      while (!ref_req && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      chk("reach_req_before_reset", int'(ref_req), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ref_req", int'(ref_req), 0);
      chk("rst_lk_req", int'(lk_req), 0);
      chk("rst_lk_row", int'(lk_row), 0);
      chk("rst_ref_row", int'(ref_row), 0);
      chk("rst_ref_busy", int'(ref_busy), 0);
      chk("rst_credit", int'(credit), 0);
      chk("rst_urgent", int'(ref_urgent), 0);
      chk("rst_skip", int'(skip_cnt), 0);
      chk("rst_overflow", int'(ref_overflow), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_cycles(40, 1, 0, 3);
      chk("post_reset_first_lk", first_lk_cyc, 11);
      chk("post_reset_first_req", first_req_cyc, 13);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
